pipe_sel_reg: RTL and testbench
===============================

Name: pipe_sel_reg

Overview:
Parametrised N-input, W-bit operand-select stage with a registered output, for operand/forwarding selection between pipeline stages of the 6-stage CPU. It selects one of NUM_IN sources and checks that the chosen source is valid, raising a hazard otherwise. It then latches the result into a pipeline register with stall, flush and valid handshake. A saturating hazard-cycle counter supports stall diagnostics.

Parameters:
WIDTH, 16, data width of each source and of out_data
NUM_IN, 8, number of selectable sources (legal range 2..16)
SEL_W, $clog2(NUM_IN), select width (derived; do not override)
CNT_W, 8, width of the saturating hazard counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  NUM_IN*WIDTH  flattened sources; source k = in_data[k*WIDTH +: WIDTH]
in_valid  input  NUM_IN  per-source valid; 1 = source k holds a usable value this cycle
select  input  SEL_W  source index
req_valid  input  1  upstream presents a valid request this cycle
stall  input  1  downstream stall; hold the stage register
flush  input  1  kill the stage contents
out_data  output  WIDTH  registered selected data
out_valid  output  1  registered valid
hazard  output  1  combinational; request cannot be served this cycle
sel_err  output  1  combinational; select >= NUM_IN while req_valid
hazard_cnt  output  CNT_W  saturating count of cycles with hazard=1

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset; no asynchronous paths.
- Reset, at the clk edge with reset=1:
  - out_data=0, out_valid=0, hazard_cnt=0.
  - reset overrides flush, stall and all other inputs.
- sel_err = req_valid & (select >= NUM_IN). This is constant 0 when NUM_IN is a power of two.
- hazard = req_valid & ~sel_err & ~in_valid[select].
- Combinational paths:
  - hazard and sel_err are combinational from select, req_valid and in_valid; no register in the path.
  - Upstream uses hazard to stall itself in the same cycle.
- Accept condition: acc = req_valid & ~hazard & ~sel_err.
- Register update per edge (reset=0), highest priority first:
  1. flush=1: out_valid<=0; out_data holds. Flush wins over stall.
  2. stall=1: out_valid and out_data hold.
  3. acc=1: out_data<=selected source; out_valid<=1.
  4. otherwise: out_valid<=0, inserting a bubble; out_data holds its last value and does not toggle on bubbles.
- Latency: exactly 1 cycle from an accepted request to out_valid/out_data.
- Full throughput: one accept per cycle when stall=0.
- hazard_cnt:
  - Increments by 1 on each edge where hazard=1, regardless of stall or flush.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Clears only on reset.
- sel_err drops the request, producing a bubble; it does not increment hazard_cnt.
- Simultaneous flush and acc: flush wins and the accepted data is discarded (out_valid=0).
- Simultaneous stall and hazard: the register holds and hazard_cnt still counts.
- Reset mid-stall: out_valid=0 on the next cycle. Stalled data is lost; this is intended.
- Arithmetic: none on data. The select compare is unsigned.

Decomposition:
- Shared package cpu_pipe_pkg:
  - DATA_W=16 default.
  - Localparam for source indices used by the forwarding unit: SRC_RF, SRC_EX, SRC_MEM, SRC_WB, ...
  - A function for the flattened-bus slice offset.
- One sub-module is natural: mux_nto1_param (WIDTH, NUM_IN), the purely combinational indexed selector.
- pipe_sel_reg instantiates mux_nto1_param and adds the checks, register and counter.

Test Plan:
- Reset and basic select: WIDTH=16, NUM_IN=8, all in_valid=1, source k=16'h1000+k; cycle through select 0..7 with req_valid=1 -> out_data=16'h1000+k one cycle later, out_valid=1 every cycle.
- Hazard: select=3, in_valid[3]=0 for 3 cycles, then 1 -> hazard=1 for 3 cycles, out_valid=0 for those 3 cycles, hazard_cnt=3, then out_data=16'h1003 with out_valid=1.
- Stall/flush priority:
  - Accept 16'hBEEF, then assert stall 2 cycles -> out_data=16'hBEEF, out_valid=1 held.
  - Then assert stall=1 and flush=1 together -> out_valid=0, out_data stays 16'hBEEF.
- Non-power-of-two: NUM_IN=5, select=6, req_valid=1 -> sel_err=1, hazard=0, out_valid=0 next cycle, hazard_cnt unchanged.
- Counter saturation: CNT_W=3, hold hazard=1 for 10 cycles -> hazard_cnt reaches 7 and stays 7.
- Reset mid-operation: stream valid requests, assert reset for 1 cycle together with stall=1 -> out_data=0, out_valid=0, hazard_cnt=0 next cycle; the stream resumes with 1-cycle latency.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline operand-select stages: default widths,
// forwarding source indices and the flattened-bus slice helper.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned NUM_SRC_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;

  // Source indices used by the forwarding unit when driving select.
  localparam int unsigned SRC_RF  = 0;
  localparam int unsigned SRC_EX  = 1;
  localparam int unsigned SRC_MEM = 2;
  localparam int unsigned SRC_WB  = 3;
  localparam int unsigned SRC_IMM = 4;
  localparam int unsigned SRC_PC  = 5;
  localparam int unsigned SRC_CSR = 6;
  localparam int unsigned SRC_ZERO = 7;

  // Low bit of source idx inside a flattened bus of w-bit entries.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pipe_sel_reg_if.sv
// Source/request/handshake bundle of the operand-select pipeline stage.
interface pipe_sel_reg_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [SEL_W-1:0]        select;
  logic                    req_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    hazard;
  logic                    sel_err;
  logic [CNT_W-1:0]        hazard_cnt;

  modport master (
    output in_data, in_valid, select, req_valid, stall, flush,
    input  out_data, out_valid, hazard, sel_err, hazard_cnt
  );

  modport slave (
    input  in_data, in_valid, select, req_valid, stall, flush,
    output out_data, out_valid, hazard, sel_err, hazard_cnt
  );

endinterface

// File: rtl/pipe_sel_reg_mux.sv
// Purely combinational N-to-1 indexed selector over a flattened source bus.
module mux_nto1_param
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned NUM_IN = NUM_SRC_DEF,
  parameter int unsigned SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        sel_data_c
);

  // Out-of-range selects yield zero; the caller flags them separately.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) begin
        sel_data_c = in_data[slice_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pipe_sel_reg.sv
// Operand-select stage: indexed source mux, validity/range checks, registered
// output with stall/flush/valid handshake and a saturating hazard counter.
module pipe_sel_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned NUM_IN = NUM_SRC_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pipe_sel_reg_if.slave bus
);

  localparam int unsigned SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned NUM_PAD = 1 << SEL_W;

  logic [WIDTH-1:0]   sel_data_c;
  logic [NUM_PAD-1:0] valid_pad;
  logic               sel_valid;
  logic               sel_err_c;
  logic               hazard_c;
  logic               acc;

  logic [WIDTH-1:0]   out_data_q,   out_data_d;
  logic               out_valid_q,  out_valid_d;
  logic [CNT_W-1:0]   hazard_cnt_q, hazard_cnt_d;

  mux_nto1_param #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .in_data    (bus.in_data),
    .select     (bus.select),
    .sel_data_c (sel_data_c)
  );

  // Range and validity checks; padding keeps the valid lookup in bounds.
  always_comb begin
    valid_pad = NUM_PAD'(bus.in_valid);
    sel_valid = valid_pad[bus.select];
    sel_err_c = bus.req_valid & ({1'b0, bus.select} >= (SEL_W+1)'(NUM_IN));
    hazard_c  = bus.req_valid & ~sel_err_c & ~sel_valid;
    acc       = bus.req_valid & ~hazard_c & ~sel_err_c;
  end

  // Stage register next state: flush > stall > accept > bubble.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    hazard_cnt_d = hazard_cnt_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (!bus.stall) begin
      if (acc) begin
        out_data_d  = sel_data_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (hazard_c && (hazard_cnt_q != {CNT_W{1'b1}})) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      hazard_cnt_q <= '0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.hazard     = hazard_c;
  assign bus.sel_err    = sel_err_c;
  assign bus.hazard_cnt = hazard_cnt_q;

endmodule

// File: tb/tb_pipe_sel_reg.sv
// Scoreboard bench for pipe_sel_reg: an 8-source/8-bit-counter instance and a
// 5-source/3-bit-counter instance share one stimulus stream.
module tb_pipe_sel_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_sel_reg_if #(.WIDTH(16), .NUM_IN(8), .CNT_W(8)) ifa ();
  pipe_sel_reg_if #(.WIDTH(16), .NUM_IN(5), .CNT_W(3)) ifb ();

  pipe_sel_reg #(.WIDTH(16), .NUM_IN(8), .CNT_W(8)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  pipe_sel_reg #(.WIDTH(16), .NUM_IN(5), .CNT_W(3)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [7:0]  c;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] src [8];
  logic        mv  [2];
  logic [15:0] md  [2];
  int          mc  [2];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: drive, check combinational flags, predict, then compare registers.
  task automatic apply(input logic r, input logic [2:0] sel, input logic rq,
                       input logic st, input logic fl, input logic [7:0] iv);
    int   num, cmax;
    logic se, hz;
    string p;
    exp_t e;
    @(negedge clk);
    rst = r;
    ifa.select = sel;  ifb.select = sel;
    ifa.req_valid = rq; ifb.req_valid = rq;
    ifa.stall = st;    ifb.stall = st;
    ifa.flush = fl;    ifb.flush = fl;
    ifa.in_valid = iv; ifb.in_valid = iv[4:0];
    for (int k = 0; k < 8; k++) ifa.in_data[k*16 +: 16] = src[k];
    for (int k = 0; k < 5; k++) ifb.in_data[k*16 +: 16] = src[k];
    #1;
    for (int i = 0; i < 2; i++) begin
      num  = (i == 0) ? 8 : 5;
      cmax = (i == 0) ? 255 : 7;
      p    = (i == 0) ? "a" : "b";
      se   = rq && (int'(sel) >= num);
      hz   = rq && !se && !iv[sel];
      chk({p, "_hazard"},  (i == 0) ? ifa.hazard  : ifb.hazard,  hz);
      chk({p, "_sel_err"}, (i == 0) ? ifa.sel_err : ifb.sel_err, se);
      if (r) begin
        mv[i] = 1'b0; md[i] = '0; mc[i] = 0;
      end else begin
        if (hz && mc[i] != cmax) mc[i]++;
        if (fl) mv[i] = 1'b0;
        else if (!st) begin
          if (rq && !hz && !se) begin md[i] = src[sel]; mv[i] = 1'b1; end
          else mv[i] = 1'b0;
        end
      end
      sb_q.push_back('{mv[i], md[i], 8'(mc[i])});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "a" : "b";
      e = sb_q.pop_front();
      chk({p, "_out_valid"},  (i == 0) ? ifa.out_valid  : ifb.out_valid,  e.v);
      chk({p, "_out_data"},   (i == 0) ? ifa.out_data   : ifb.out_data,   e.d);
      chk({p, "_hazard_cnt"}, (i == 0) ? 32'(ifa.hazard_cnt) : 32'(ifb.hazard_cnt), e.c);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) src[k] = 16'h1000 + 16'(k);
    for (int i = 0; i < 2; i++) begin mv[i] = 1'b0; md[i] = '0; mc[i] = 0; end

    // Reset, with flush/stall/request asserted to show reset dominates.
    apply(1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 8'hFF);
    apply(1'b1, 3'd0, 1'b0, 1'b0, 0, 8'hFF);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_cnt", ifa.hazard_cnt, 0);

    // Basic select sweep; sources 5..7 are out of range for the 5-input instance.
    for (int k = 0; k < 8; k++) apply(1'b0, 3'(k), 1'b1, 1'b0, 1'b0, 8'hFF);
    chk("basic_last_data", ifa.out_data, 16'h1007);
    chk("basic_last_valid", ifa.out_valid, 1);

    // Hazard on source 3 for three cycles, then it becomes valid.
    for (int k = 0; k < 3; k++) apply(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF7);
    apply(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hFF);
    chk("hz_cnt3", ifa.hazard_cnt, 3);
    chk("hz_data", ifa.out_data, 16'h1003);
    chk("hz_valid", ifa.out_valid, 1);

    // Accept BEEF, stall twice, then stall+flush together.
    src[2] = 16'hBEEF;
    apply(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'hFF);
    apply(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 8'hFF);
    apply(1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 8'hFF);
    chk("stall_hold_data", ifa.out_data, 16'hBEEF);
    chk("stall_hold_valid", ifa.out_valid, 1);
    apply(1'b0, 3'd1, 1'b1, 1'b1, 1'b1, 8'hFF);
    chk("flush_valid", ifa.out_valid, 0);
    chk("flush_data", ifa.out_data, 16'hBEEF);

    // Out-of-range select on the 5-input instance: bubble, counter untouched.
    apply(1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 8'hFF);
    chk("selerr_valid", ifb.out_valid, 0);
    chk("selerr_cnt", ifb.hazard_cnt, 3);

    // Ten hazard cycles saturate the 3-bit counter at 7.
    for (int k = 0; k < 10; k++) apply(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 8'hF7);
    chk("sat_cnt_b", ifb.hazard_cnt, 7);
    chk("sat_cnt_a", ifa.hazard_cnt, 13);

    // Random mix of requests, stalls, flushes and invalid sources.
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 8; k++) src[k] = 16'($urandom);
      apply(1'b0, 3'($urandom_range(0, 7)), ($urandom % 4) != 0,
            ($urandom % 5) == 0, ($urandom % 7) == 0, 8'($urandom));
    end

    // Reset during a stall while a stream is running, then resume.
    for (int k = 0; k < 8; k++) src[k] = 16'h2000 + 16'(k);
    apply(1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'hFF);
    apply(1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 8'hFF);
    chk("midrst_valid", ifa.out_valid, 0);
    chk("midrst_data", ifa.out_data, 0);
    chk("midrst_cnt", ifb.hazard_cnt, 0);
    apply(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 8'hFF);
    chk("resume_data", ifa.out_data, 16'h2002);
    chk("resume_valid", ifa.out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
